// File: rtl/hazard_pkg.sv
// Shared encodings for the RV32I hazard/forwarding controller.
// Forward-mux selects and the hazard FSM state type.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LD_STALL = 2'b01,
    ST_FLUSH    = 2'b10
  } hz_state_e;

endpackage

// File: rtl/hazard_fwd_cmp.sv
// One source operand against the EX/WB shadow slots.
// Yields the operand mux select and a load-use flag.
module hazard_fwd_cmp
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic              i_rs_used,
  input  logic              i_ex_v,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_we,
  input  logic              i_ex_ld,
  input  logic              i_wb_v,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_we,
  output logic [1:0]        o_sel,
  output logic              o_ld_use
);

  logic w_rs_live;
  logic w_ex_hit;
  logic w_wb_hit;
  logic w_wb_only;

  assign w_rs_live = i_rs_used & (|i_rs);
  assign w_ex_hit  = w_rs_live & i_ex_v & i_ex_we
                   & (i_ex_rd == i_rs);
  assign w_wb_hit  = w_rs_live & i_wb_v & i_wb_we
                   & (i_wb_rd == i_rs);
  assign w_wb_only = w_wb_hit & ~w_ex_hit;

  // A load in EX has no data yet; the FSM stalls instead.
  assign o_ld_use = w_ex_hit & i_ex_ld;

  always_comb begin
    o_sel = FWD_RF;
    unique case (1'b1)
      w_ex_hit:  o_sel = i_ex_ld ? FWD_RF : FWD_EX;
      w_wb_only: o_sel = FWD_WB;
      default:   o_sel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller: forwarding selects, load-use stall, redirect flush.
// Define HAZARD_PERF_EN to add saturating stall/flush cycle counters.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_we,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  input  logic              mem_ready,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic              flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

  localparam logic [1:0] FL_RELOAD = 2'(FLUSH_CYCLES - 1);

  if (CNT_W < 1 || FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3)
  begin : g_bad_param
    $error("hazard_fwd_ctrl: illegal parameter");
  end

  hz_state_e         r_state;
  hz_state_e         w_state_nxt;
  logic [1:0]        r_fl_cnt;
  logic [1:0]        w_fl_cnt_nxt;

  logic              r_ex_v;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_we;
  logic              r_ex_ld;
  logic              r_wb_v;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_we;

  logic              w_lu_a;
  logic              w_lu_b;
  logic              w_ld_use;

  hazard_fwd_cmp #(.REG_AW(REG_AW)) u_cmp_a (
    .i_rs      (id_rs1),
    .i_rs_used (id_rs1_used),
    .i_ex_v    (r_ex_v),
    .i_ex_rd   (r_ex_rd),
    .i_ex_we   (r_ex_we),
    .i_ex_ld   (r_ex_ld),
    .i_wb_v    (r_wb_v),
    .i_wb_rd   (r_wb_rd),
    .i_wb_we   (r_wb_we),
    .o_sel     (fwd_a_sel),
    .o_ld_use  (w_lu_a)
  );

  hazard_fwd_cmp #(.REG_AW(REG_AW)) u_cmp_b (
    .i_rs      (id_rs2),
    .i_rs_used (id_rs2_used),
    .i_ex_v    (r_ex_v),
    .i_ex_rd   (r_ex_rd),
    .i_ex_we   (r_ex_we),
    .i_ex_ld   (r_ex_ld),
    .i_wb_v    (r_wb_v),
    .i_wb_rd   (r_wb_rd),
    .i_wb_we   (r_wb_we),
    .o_sel     (fwd_b_sel),
    .o_ld_use  (w_lu_b)
  );

  assign w_ld_use = w_lu_a | w_lu_b;

  always_comb begin
    w_state_nxt  = r_state;
    w_fl_cnt_nxt = r_fl_cnt;
    stall        = 1'b0;
    flush        = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (ex_redirect) begin
          flush        = 1'b1;
          w_fl_cnt_nxt = FL_RELOAD;
          w_state_nxt  = (FL_RELOAD == 2'd0) ? ST_RUN
                                             : ST_FLUSH;
        end else if (id_valid && w_ld_use) begin
          stall       = 1'b1;
          w_state_nxt = ST_LD_STALL;
        end
      end
      ST_LD_STALL: begin
        stall = 1'b1;
        if (mem_ready) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (ex_redirect) begin
          w_fl_cnt_nxt = FL_RELOAD;
        end else begin
          w_fl_cnt_nxt = r_fl_cnt - 2'd1;
        end
        if (w_fl_cnt_nxt == 2'd0) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt  = ST_RUN;
        w_fl_cnt_nxt = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_fl_cnt <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_fl_cnt <= w_fl_cnt_nxt;
    end
  end

  // The stalled load waits in WB for its data, so WB holds in LD_STALL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_v  <= 1'b0;
      r_wb_rd <= '0;
      r_wb_we <= 1'b0;
    end else if (r_state != ST_LD_STALL) begin
      r_wb_v  <= r_ex_v;
      r_wb_rd <= r_ex_rd;
      r_wb_we <= r_ex_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_v  <= 1'b0;
      r_ex_rd <= '0;
      r_ex_we <= 1'b0;
      r_ex_ld <= 1'b0;
    end else if (stall || flush) begin
      r_ex_v  <= 1'b0;
      r_ex_rd <= '0;
      r_ex_we <= 1'b0;
      r_ex_ld <= 1'b0;
    end else begin
      r_ex_v  <= id_valid;
      r_ex_rd <= id_rd;
      r_ex_we <= id_reg_we;
      r_ex_ld <= id_is_load;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && !(&perf_stall_cnt)) begin
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
      if (flush && !(&perf_flush_cnt)) begin
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed instruction stream plus a
// per-cycle reference model; perf counters checked with HAZARD_PERF_EN.
module tb_hazard_fwd_ctrl;

  localparam int AW   = 5;
  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int PMAX = (1 << CW) - 1;

  localparam int M_RUN = 0;
  localparam int M_LD  = 1;
  localparam int M_FL  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs1 = '0;
  logic [AW-1:0] id_rs2 = '0;
  logic          id_rs1_used = 1'b0;
  logic          id_rs2_used = 1'b0;
  logic [AW-1:0] id_rd = '0;
  logic          id_reg_we = 1'b0;
  logic          id_is_load = 1'b0;
  logic          ex_redirect = 1'b0;
  logic          mem_ready = 1'b0;
  logic [1:0]    fwd_a_sel;
  logic [1:0]    fwd_b_sel;
  logic          stall;
  logic          flush;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] perf_stall_cnt;
  logic [CW-1:0] perf_flush_cnt;
`endif

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(
    .REG_AW       (AW),
    .FLUSH_CYCLES (FC),
    .CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_reg_we   (id_reg_we),
    .id_is_load  (id_is_load),
    .ex_redirect (ex_redirect),
    .mem_ready   (mem_ready),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall       (stall),
    .flush       (flush)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          v;
    logic [AW-1:0] rd;
    logic          we;
    logic          ld;
  } ins_t;

  ins_t m_ex;
  ins_t m_wb;
  int   m_mode;
  int   m_left;
  int   m_pst;
  int   m_pfl;

  function automatic logic writes(input ins_t s, input logic [AW-1:0] rs,
                                  input logic used);
    return used && (rs != 0) && s.v && s.we && (s.rd == rs);
  endfunction

  function automatic logic [1:0] exp_sel(input logic [AW-1:0] rs,
                                         input logic used);
    if (writes(m_ex, rs, used)) return m_ex.ld ? 2'b00 : 2'b01;
    if (writes(m_wb, rs, used)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic load_use();
    return (writes(m_ex, id_rs1, id_rs1_used) ||
            writes(m_ex, id_rs2, id_rs2_used)) && m_ex.ld;
  endfunction

  function automatic logic exp_flush();
    return (m_mode == M_FL) || (m_mode == M_RUN && ex_redirect);
  endfunction

  function automatic logic exp_stall();
    if (m_mode == M_LD) return 1'b1;
    return m_mode == M_RUN && !ex_redirect && id_valid && load_use();
  endfunction

  function automatic int nxt_left();
    if (m_mode == M_RUN && ex_redirect) return FC - 1;
    if (m_mode == M_FL) return ex_redirect ? FC - 1 : m_left - 1;
    return m_left;
  endfunction

  function automatic int nxt_mode();
    if (m_mode == M_RUN) begin
      if (ex_redirect) return (FC > 1) ? M_FL : M_RUN;
      if (exp_stall()) return M_LD;
      return M_RUN;
    end
    if (m_mode == M_LD) return mem_ready ? M_RUN : M_LD;
    return (nxt_left() == 0) ? M_RUN : M_FL;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex   <= '0;
      m_wb   <= '0;
      m_mode <= M_RUN;
      m_left <= 0;
      m_pst  <= 0;
      m_pfl  <= 0;
    end else begin
      m_mode <= nxt_mode();
      m_left <= nxt_left();
      if (exp_stall() && m_pst < PMAX) m_pst <= m_pst + 1;
      if (exp_flush() && m_pfl < PMAX) m_pfl <= m_pfl + 1;
      if (m_mode != M_LD) m_wb <= m_ex;
      if (exp_stall() || exp_flush()) m_ex <= '0;
      else m_ex <= '{id_valid, id_rd, id_reg_we, id_is_load};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_fwd_a", 32'(fwd_a_sel), 32'(exp_sel(id_rs1, id_rs1_used)));
      chk("cmp_fwd_b", 32'(fwd_b_sel), 32'(exp_sel(id_rs2, id_rs2_used)));
      chk("cmp_stall", 32'(stall), 32'(exp_stall()));
      chk("cmp_flush", 32'(flush), 32'(exp_flush()));
`ifdef HAZARD_PERF_EN
      chk("cmp_pstall", 32'(perf_stall_cnt), 32'(m_pst));
      chk("cmp_pflush", 32'(perf_flush_cnt), 32'(m_pfl));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic v, input int rs1, input logic u1,
                       input int rs2, input logic u2, input int rd,
                       input logic we, input logic ld, input logic rdr,
                       input logic mr);
    @(posedge clk);
    #1;
    id_valid    = v;
    id_rs1      = AW'(rs1);
    id_rs1_used = u1;
    id_rs2      = AW'(rs2);
    id_rs2_used = u2;
    id_rd       = AW'(rd);
    id_reg_we   = we;
    id_is_load  = ld;
    ex_redirect = rdr;
    mem_ready   = mr;
    @(negedge clk);
  endtask

  task automatic hold(input logic mr);
    @(posedge clk);
    #1;
    mem_ready = mr;
    @(negedge clk);
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("rst_fwd_b", 32'(fwd_b_sel), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    rst_n = 1'b1;

    // back-to-back dependency on x5
    issue(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    issue(1, 5, 1, 0, 0, 6, 0, 0, 0, 0);
    chk("b2b_fwd_a_ex", 32'(fwd_a_sel), 32'd1);
    chk("b2b_stall", 32'(stall), 32'd0);
    issue(1, 0, 0, 5, 1, 6, 0, 0, 0, 0);
    chk("b2b_fwd_b_wb", 32'(fwd_b_sel), 32'd2);

    // x0 never forwards; EX beats WB
    issue(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    issue(1, 0, 1, 0, 1, 8, 0, 0, 0, 0);
    chk("x0_fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("x0_fwd_b", 32'(fwd_b_sel), 32'd0);
    issue(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    issue(1, 7, 1, 7, 1, 8, 0, 0, 0, 0);
    chk("prio_fwd_a", 32'(fwd_a_sel), 32'd1);
    chk("prio_fwd_b", 32'(fwd_b_sel), 32'd1);

    // load-use on x3: three stall cycles, release, then WB forward
    issue(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    issue(1, 3, 1, 0, 0, 9, 1, 0, 0, 0);
    chk("lu_stall1", 32'(stall), 32'd1);
    chk("lu_sel_ld", 32'(fwd_a_sel), 32'd0);
    hold(0);
    chk("lu_stall2", 32'(stall), 32'd1);
    hold(0);
    chk("lu_stall3", 32'(stall), 32'd1);
    hold(1);
    chk("lu_rdy_stall", 32'(stall), 32'd1);
    hold(0);
    chk("lu_done_stall", 32'(stall), 32'd0);
    chk("lu_done_sel", 32'(fwd_a_sel), 32'd2);
    nop();

    // redirect holds flush for two cycles
    issue(1, 0, 0, 0, 0, 9, 1, 0, 1, 0);
    chk("rd_flush1", 32'(flush), 32'd1);
    nop();
    chk("rd_flush2", 32'(flush), 32'd1);
    nop();
    chk("rd_flush_end", 32'(flush), 32'd0);

    // redirect coincident with load-use
    issue(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    issue(1, 4, 1, 0, 0, 9, 1, 0, 1, 0);
    chk("co_flush", 32'(flush), 32'd1);
    chk("co_stall", 32'(stall), 32'd0);
    issue(1, 4, 1, 0, 0, 9, 1, 0, 0, 0);
    chk("co_flush2", 32'(flush), 32'd1);
    chk("co_stall2", 32'(stall), 32'd0);
    nop();
    chk("co_end", 32'(flush | stall), 32'd0);

    // redirect during flush restarts the count
    issue(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("rs_flush_b", 32'(flush), 32'd1);
    nop();
    chk("rs_flush_c", 32'(flush), 32'd1);
    nop();
    chk("rs_flush_end", 32'(flush), 32'd0);

    // asynchronous reset in the middle of a load stall
    issue(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    issue(1, 3, 1, 0, 0, 9, 1, 0, 0, 0);
    hold(0);
    chk("ar_pre_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_stall", 32'(stall), 32'd0);
    chk("ar_fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("ar_fwd_b", 32'(fwd_b_sel), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    hold(0);
    chk("ar_run_stall", 32'(stall), 32'd0);

    // long stall for counter saturation
    issue(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    issue(1, 3, 1, 0, 0, 9, 1, 0, 0, 0);
    repeat (20) hold(0);
    chk("sat_stall", 32'(stall), 32'd1);
`ifdef HAZARD_PERF_EN
    chk("sat_pstall", 32'(perf_stall_cnt), 32'hF);
    chk("sat_pflush", 32'(perf_flush_cnt), 32'h0);
`endif
    hold(1);
    nop();
    nop();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
